// File: rtl/mem_arbiter_pkg.sv
// Shared memory-side definitions for the fetch/data memory arbiter.
package mem_arbiter_pkg;

    localparam logic MEM_ROM = 1'b0;
    localparam logic MEM_RAM = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Bookkeeping carried from accept to the response cycle
    typedef struct packed {
        logic owner;  // 1 = data port
        logic write;
        logic err;
    } req_meta_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter with a last-grant pointer and one-hot grant.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant_c
);

    // 1 = requester 1 won last; reset value lets requester 0 win first contention
    logic last_grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant_c[1];
        end
    end

    always_comb begin
        grant_c = 2'b00;
        case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = last_grant ? 2'b01 : 2'b10;
            default: grant_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one memory, one access per two cycles.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_write,
    input  logic              d_req_type,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              d_rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_input_data,
    output logic              mem_write,
    output logic              mem_read,
    output logic              mem_type,
    input  logic [DATA_W-1:0] mem_output_data,
    output logic              grant_data
);

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH);

    arb_state_t        state;
    arb_state_t        state_nxt;
    req_meta_t         cur;
    logic [1:0]        grant_c;
    logic              open_c;
    logic              accept_c;
    logic              sel_data_c;
    logic              sel_write_c;
    logic              sel_err_c;
    logic [ADDR_W-1:0] sel_addr_c;
    logic [DATA_W-1:0] rsp_word_c;

    assign open_c = !reset && ((state == IDLE) || (state == RESP));

    rr_arbiter2 u_rr (
        .clock   (clock),
        .reset   (reset),
        .req     ({d_req_valid, if_req_valid} & {2{open_c}}),
        .advance (accept_c),
        .grant_c (grant_c)
    );

    assign if_req_ready = grant_c[0];
    assign d_req_ready  = grant_c[1];
    assign accept_c     = |grant_c;

    // Granted request, muxed for registration at accept
    assign sel_data_c  = grant_c[1];
    assign sel_addr_c  = sel_data_c ? d_req_addr : if_req_addr;
    assign sel_write_c = sel_data_c && d_req_write;
    assign sel_err_c   = {1'b0, sel_addr_c} >= ADDR_LIMIT;
    assign rsp_word_c  = (cur.err || cur.write) ? '0 : mem_output_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = accept_c ? ACCESS : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory strobes live only in ACCESS; responses are captured as ACCESS ends
    always_ff @(posedge clock) begin
        if (reset) begin
            cur            <= '0;
            mem_address    <= '0;
            mem_input_data <= '0;
            mem_type       <= MEM_ROM;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            grant_data     <= 1'b0;
            if_rsp_valid   <= 1'b0;
            if_rsp_data    <= '0;
            if_rsp_err     <= 1'b0;
            d_rsp_valid    <= 1'b0;
            d_rsp_data     <= '0;
            d_rsp_err      <= 1'b0;
        end else begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            if (accept_c) begin
                cur.owner      <= sel_data_c;
                cur.write      <= sel_write_c;
                cur.err        <= sel_err_c;
                mem_address    <= sel_addr_c;
                mem_type       <= sel_data_c ? d_req_type : MEM_ROM;
                mem_input_data <= sel_data_c ? d_req_wdata : '0;
                mem_read       <= !sel_err_c && !sel_write_c;
                mem_write      <= !sel_err_c && sel_write_c;
                grant_data     <= sel_data_c;
            end
            if (state == ACCESS) begin
                if (cur.owner) begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_data  <= rsp_word_c;
                    d_rsp_err   <= cur.err;
                end else begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_data  <= rsp_word_c;
                    if_rsp_err   <= cur.err;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: accept-time scoreboard checked against memory strobes and responses.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;

    logic          clock = 1'b0;
    logic          reset;
    logic          if_req_valid, if_req_ready;
    logic [AW-1:0] if_req_addr;
    logic          if_rsp_valid, if_rsp_err;
    logic [DW-1:0] if_rsp_data;
    logic          d_req_valid, d_req_ready, d_req_write, d_req_type;
    logic [AW-1:0] d_req_addr;
    logic [DW-1:0] d_req_wdata;
    logic          d_rsp_valid, d_rsp_err;
    logic [DW-1:0] d_rsp_data;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_input_data, mem_output_data;
    logic          mem_write, mem_read, mem_type, grant_data;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;

    logic [31:0] rom [64];
    logic [31:0] ram [64];
    logic [31:0] model_ram [64];

    typedef struct {
        int unsigned acc;
        logic        owner;
        logic        rd;
        logic        wr;
        logic        typ;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        err;
    } txn_t;

    txn_t        mq[$];
    txn_t        fq[$];
    txn_t        dq[$];
    txn_t        mon_t;
    int unsigned acc_log[$];
    logic        own_log[$];

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clock           (clock),
        .reset           (reset),
        .if_req_valid    (if_req_valid),
        .if_req_ready    (if_req_ready),
        .if_req_addr     (if_req_addr),
        .if_rsp_valid    (if_rsp_valid),
        .if_rsp_data     (if_rsp_data),
        .if_rsp_err      (if_rsp_err),
        .d_req_valid     (d_req_valid),
        .d_req_ready     (d_req_ready),
        .d_req_write     (d_req_write),
        .d_req_type      (d_req_type),
        .d_req_addr      (d_req_addr),
        .d_req_wdata     (d_req_wdata),
        .d_rsp_valid     (d_rsp_valid),
        .d_rsp_data      (d_rsp_data),
        .d_rsp_err       (d_rsp_err),
        .mem_address     (mem_address),
        .mem_input_data  (mem_input_data),
        .mem_write       (mem_write),
        .mem_read        (mem_read),
        .mem_type        (mem_type),
        .mem_output_data (mem_output_data),
        .grant_data      (grant_data)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Memory behind the arbiter: combinational read, write on posedge
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) ram[i] <= 32'h1000_0000 + 32'(i);
        end else if (mem_write) begin
            ram[mem_address[5:0]] <= mem_input_data;
        end
    end

    assign mem_output_data = !mem_read ? 32'hBAD0_BAD0 :
                             (mem_type == MEM_RAM) ? ram[mem_address[5:0]] : rom[mem_address[5:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void log_accept(input logic owner, input logic wr, input logic typ,
                                       input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        t.acc   = cyc;
        t.owner = owner;
        t.err   = (a >= 32'(DEPTH));
        t.rd    = !t.err && !wr;
        t.wr    = !t.err && wr;
        t.typ   = typ;
        t.addr  = a;
        t.wdata = wd;
        if (t.err || wr) t.data = 32'h0;
        else             t.data = (typ == MEM_RAM) ? model_ram[a[5:0]] : rom[a[5:0]];
        if (t.wr) model_ram[a[5:0]] = wd;
        mq.push_back(t);
        if (owner) dq.push_back(t);
        else       fq.push_back(t);
        acc_log.push_back(cyc);
        own_log.push_back(owner);
    endfunction

    // Monitor: memory strobes at accept+1, responses at accept+2, new accepts logged
    always @(negedge clock) begin
        if (reset) begin
            chk("ready_in_reset", 64'({if_req_ready, d_req_ready}), 64'd0);
            for (int i = 0; i < 64; i++) model_ram[i] = 32'h1000_0000 + 32'(i);
        end else begin
            chk("ready_onehot", 64'(if_req_ready && d_req_ready), 64'd0);
            if (mq.size() > 0 && mq[0].acc + 1 == cyc) begin
                mon_t = mq.pop_front();
                chk("mem_read", 64'(mem_read), 64'(mon_t.rd));
                chk("mem_write", 64'(mem_write), 64'(mon_t.wr));
                chk("grant_data", 64'(grant_data), 64'(mon_t.owner));
                if (mon_t.rd || mon_t.wr) begin
                    chk("mem_address", 64'(mem_address), 64'(mon_t.addr));
                    chk("mem_type", 64'(mem_type), 64'(mon_t.typ));
                end
                if (mon_t.wr) chk("mem_input_data", 64'(mem_input_data), 64'(mon_t.wdata));
            end else begin
                chk("mem_idle", 64'({mem_read, mem_write}), 64'd0);
            end
            if (if_rsp_valid) begin
                if (fq.size() == 0) chk("if_rsp_unexpected", 64'd1, 64'd0);
                else begin
                    mon_t = fq.pop_front();
                    chk("if_rsp_data", 64'(if_rsp_data), 64'(mon_t.data));
                    chk("if_rsp_err", 64'(if_rsp_err), 64'(mon_t.err));
                    chk("if_rsp_latency", 64'(cyc), 64'(mon_t.acc + 2));
                end
            end else if (fq.size() > 0 && cyc > fq[0].acc + 2) begin
                chk("if_rsp_missing", 64'd0, 64'd1);
                void'(fq.pop_front());
            end
            if (d_rsp_valid) begin
                if (dq.size() == 0) chk("d_rsp_unexpected", 64'd1, 64'd0);
                else begin
                    mon_t = dq.pop_front();
                    chk("d_rsp_data", 64'(d_rsp_data), 64'(mon_t.data));
                    chk("d_rsp_err", 64'(d_rsp_err), 64'(mon_t.err));
                    chk("d_rsp_latency", 64'(cyc), 64'(mon_t.acc + 2));
                end
            end else if (dq.size() > 0 && cyc > dq[0].acc + 2) begin
                chk("d_rsp_missing", 64'd0, 64'd1);
                void'(dq.pop_front());
            end
            if (if_req_valid && if_req_ready) log_accept(1'b0, 1'b0, MEM_ROM, if_req_addr, 32'h0);
            if (d_req_valid && d_req_ready)   log_accept(1'b1, d_req_write, d_req_type, d_req_addr, d_req_wdata);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for the port's ready, then return just after the accepting edge
    task automatic wait_ready(input logic port);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            got = port ? d_req_ready : if_req_ready;
        end
        if (!got) chk("ready_timeout", 64'd0, 64'd1);
        step(1);
    endtask

    task automatic fetch(input logic [31:0] a);
        if_req_valid = 1'b1;
        if_req_addr  = a;
        wait_ready(1'b0);
        if_req_valid = 1'b0;
    endtask

    task automatic dreq(input logic wr, input logic typ, input logic [31:0] a, input logic [31:0] wd);
        d_req_valid = 1'b1;
        d_req_write = wr;
        d_req_type  = typ;
        d_req_addr  = a;
        d_req_wdata = wd;
        wait_ready(1'b1);
        d_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && (mq.size() + fq.size() + dq.size()) != 0; i++) step(1);
        chk("drain", 64'(mq.size() + fq.size() + dq.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n0;
        for (int i = 0; i < 64; i++) rom[i] = 32'hA500_0000 | 32'(i);
        rom[0] = 32'h0010_0113;

        // Reset with both valids high: readies must stay low
        reset        = 1'b1;
        if_req_valid = 1'b1;
        if_req_addr  = 32'h0;
        d_req_valid  = 1'b1;
        d_req_write  = 1'b0;
        d_req_type   = MEM_RAM;
        d_req_addr   = 32'h0;
        d_req_wdata  = 32'h0;
        step(2);
        @(negedge clock);
        chk("rst_mem_read", 64'(mem_read), 64'd0);
        chk("rst_mem_write", 64'(mem_write), 64'd0);
        chk("rst_if_rsp_valid", 64'(if_rsp_valid), 64'd0);
        chk("rst_d_rsp_valid", 64'(d_rsp_valid), 64'd0);
        chk("rst_rsp_err", 64'({if_rsp_err, d_rsp_err}), 64'd0);
        chk("rst_grant_data", 64'(grant_data), 64'd0);
        chk("rst_mem_address", 64'(mem_address), 64'd0);
        chk("rst_mem_input_data", 64'(mem_input_data), 64'd0);
        chk("rst_rsp_data", 64'({if_rsp_data, d_rsp_data}), 64'd0);
        chk("rst_mem_type", 64'(mem_type), 64'(MEM_ROM));
        step(1);

        // Contention straight out of reset: fetch first, then strict alternation
        reset        = 1'b0;
        n0           = acc_log.size();
        if_req_addr  = 32'd2;
        d_req_addr   = 32'd5;
        step(8);
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        drain();
        chk("rr_accept_count", 64'(acc_log.size() - n0), 64'd4);
        if (acc_log.size() - n0 == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("rr_owner", 64'(own_log[n0 + k]), 64'(k % 2));
                if (k > 0) chk("rr_spacing", 64'(acc_log[n0 + k] - acc_log[n0 + k - 1]), 64'd2);
            end
        end

        // Fetch of ROM[0]
        fetch(32'd0);
        drain();
        chk("fetch0_data", 64'(if_rsp_data), 64'h0010_0113);

        // Write then read back RAM[5], back to back
        n0 = acc_log.size();
        dreq(1'b1, MEM_RAM, 32'd5, 32'hDEAD_BEEF);
        dreq(1'b0, MEM_RAM, 32'd5, 32'h0);
        drain();
        chk("wr_rd_count", 64'(acc_log.size() - n0), 64'd2);
        if (acc_log.size() - n0 == 2) chk("wr_rd_spacing", 64'(acc_log[n0 + 1] - acc_log[n0]), 64'd2);
        step(3);
        chk("d_rsp_hold", 64'(d_rsp_data), 64'hDEAD_BEEF);

        // Address boundary: 63 valid, 64 and above are errors on either port
        dreq(1'b0, MEM_RAM, 32'd64, 32'h0);
        dreq(1'b1, MEM_RAM, 32'd70, 32'h1234_5678);
        dreq(1'b0, MEM_RAM, 32'd63, 32'h0);
        fetch(32'd64);
        fetch(32'd63);
        dreq(1'b0, MEM_ROM, 32'd3, 32'h0);
        drain();

        // Reset during ACCESS drops the access silently
        d_req_valid = 1'b1;
        d_req_write = 1'b0;
        d_req_type  = MEM_RAM;
        d_req_addr  = 32'd7;
        wait_ready(1'b1);
        d_req_valid = 1'b0;
        reset       = 1'b1;
        mq.delete();
        fq.delete();
        dq.delete();
        step(1);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_access_strobes", 64'({mem_read, mem_write}), 64'd0);
        step(3);
        fetch(32'd1);
        drain();

        // Mixed traffic
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 2) == 0) fetch(32'($urandom_range(0, 70)));
            else dreq(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 70)), $urandom);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
